// File: rtl/pipe_shift_pkg.sv
// -----------------------------------------------------------------------------
// pipe_shift_pkg
// Shared types and helpers for the pipelined barrel shifter.
//   sh_mode_e    : shift mode encoding (LSL, LSR, ASR, ROR)
//   sh_bundle_t  : per-beat payload that travels down the shift pipeline
//   sh_amt_over  : amount >= operand width
//   sh_mod_width : amount mod width for amounts below 2*width
// -----------------------------------------------------------------------------
package pipe_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_mode_e;

  // A package cannot be parametrised, so the bundle is sized for the widest
  // supported operand. Users place their operand in the low WIDTH bits; the
  // upper bits stay zero and are removed as constants by synthesis.
  localparam int SH_MAX_WIDTH = 64;
  localparam int SH_MAX_SHW   = 6;

  typedef struct packed {
    logic [SH_MAX_WIDTH-1:0] data;    // operand / partial result
    logic [SH_MAX_SHW-1:0]   amt;     // shift amount still to be applied
    sh_mode_e                mode;
    logic                    sign;    // operand MSB captured at the input
    logic                    sticky;  // OR of bits discarded by LSR/ASR
    logic                    ovf;     // OR of bits discarded by LSL
  } sh_bundle_t;

  function automatic logic sh_amt_over(input logic [SH_MAX_SHW-1:0] amt,
                                       input int width);
    return int'(amt) >= width;
  endfunction

  // The amount is narrower than 2*width (2^(SHW-1) < width), so one
  // conditional subtraction is a full modulo.
  function automatic logic [SH_MAX_SHW-1:0] sh_mod_width(
      input logic [SH_MAX_SHW-1:0] amt, input int width);
    if (int'(amt) >= width) return amt - SH_MAX_SHW'(width);
    return amt;
  endfunction

endpackage

// File: rtl/pipe_barrel_shifter_if.sv
// -----------------------------------------------------------------------------
// pipe_barrel_shifter_if
// Valid/ready handshake bundle for the pipelined barrel shifter.
//   in_valid/in_ready     : input beat handshake
//   in_data/in_amt/in_mode: operand, unsigned shift amount, shift mode
//   out_valid/out_ready   : result handshake
//   out_data              : shifted result
//   out_sticky/out_ovf    : discarded-bit flags for right/left shifts
// Modports: master drives the inputs (producer/consumer side), slave is the
// shifter.
// -----------------------------------------------------------------------------
interface pipe_barrel_shifter_if #(
  parameter int WIDTH = 24,
  parameter int SHW   = $clog2(WIDTH)
) ();
  import pipe_shift_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  sh_mode_e         in_mode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sticky, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sticky, out_ovf
  );

endinterface

// File: rtl/shift_level.sv
// -----------------------------------------------------------------------------
// shift_level
// One combinational level of the barrel shifter: shifts the bundle by DIST
// (a power of two) when the matching amount bit is set, then clears that bit.
//   i_bundle : bundle entering the level
//   o_bundle : bundle leaving the level, data shifted and flags updated
// DIST must be below WIDTH, which always holds for DIST = 2^k, k < SHW.
// -----------------------------------------------------------------------------
module shift_level
  import pipe_shift_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DIST  = 1
) (
  input  sh_bundle_t i_bundle,
  output sh_bundle_t o_bundle
);

  localparam int LVL = $clog2(DIST);

  logic [WIDTH-1:0] w_cur;
  assign w_cur = i_bundle.data[WIDTH-1:0];

  // NOTE: o_bundle gets a full default before any branch, so every path
  // assigns it and no latch can be inferred.
  always_comb begin
    o_bundle = i_bundle;
    if (i_bundle.amt[LVL]) begin
      o_bundle.amt[LVL] = 1'b0;
      unique case (i_bundle.mode)
        SH_LSL: begin
          o_bundle.data[WIDTH-1:0] = w_cur << DIST;
          o_bundle.ovf = i_bundle.ovf | (|w_cur[WIDTH-1 -: DIST]);
        end
        SH_LSR: begin
          o_bundle.data[WIDTH-1:0] = w_cur >> DIST;
          o_bundle.sticky = i_bundle.sticky | (|w_cur[DIST-1:0]);
        end
        SH_ASR: begin
          o_bundle.data[WIDTH-1:0] = {{DIST{i_bundle.sign}}, w_cur[WIDTH-1:DIST]};
          o_bundle.sticky = i_bundle.sticky | (|w_cur[DIST-1:0]);
        end
        SH_ROR: begin
          o_bundle.data[WIDTH-1:0] = {w_cur[DIST-1:0], w_cur[WIDTH-1:DIST]};
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipe_barrel_shifter
// Pipelined multi-mode barrel shifter (LSL, LSR, ASR, ROR) built from SHW
// shift_level instances. A register follows every REG_EVERY levels and the
// last level is always registered, giving latency ceil(SHW / REG_EVERY).
// The whole pipeline advances together: it moves when the output slot is
// empty or being consumed, and otherwise holds every stage, bubbles included.
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset, discards all in-flight beats
//   bus    : pipe_barrel_shifter_if slave (input and output handshakes)
// -----------------------------------------------------------------------------
module pipe_barrel_shifter
  import pipe_shift_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int SHW       = $clog2(WIDTH),
  parameter int REG_EVERY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_barrel_shifter_if.slave  bus
);

  localparam int LEVELS = SHW;

  // ---------------------------------------------------------------------------
  // Input stage: amount conditioning and out-of-range results
  // ---------------------------------------------------------------------------
  logic [SH_MAX_SHW-1:0] w_amt_ext;
  logic                  w_over;
  sh_bundle_t            w_in;

  // Amounts >= WIDTH are resolved here rather than in the levels: chaining
  // levels past the operand width would let ASR sign-fill bits leak into the
  // sticky flag. The result is produced directly and the amount is zeroed.
  always_comb begin
    w_amt_ext = SH_MAX_SHW'(bus.in_amt);
    w_over    = sh_amt_over(w_amt_ext, WIDTH);
    w_in      = '0;
    w_in.data = SH_MAX_WIDTH'(bus.in_data);
    w_in.mode = bus.in_mode;
    w_in.sign = bus.in_data[WIDTH-1];
    w_in.amt  = w_amt_ext;
    if (bus.in_mode == SH_ROR) begin
      w_in.amt = sh_mod_width(w_amt_ext, WIDTH);
    end else if (w_over) begin
      w_in.amt  = '0;
      w_in.data = '0;
      case (bus.in_mode)
        SH_LSL: w_in.ovf    = |bus.in_data;
        SH_LSR: w_in.sticky = |bus.in_data;
        SH_ASR: begin
          w_in.data[WIDTH-1:0] = {WIDTH{bus.in_data[WIDTH-1]}};
          w_in.sticky          = |bus.in_data[WIDTH-2:0];
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shift levels with optional registers
  // ---------------------------------------------------------------------------
  sh_bundle_t w_lvl_in  [LEVELS];
  sh_bundle_t w_lvl_out [LEVELS];
  logic       w_vld_in  [LEVELS];
  sh_bundle_t w_stg     [LEVELS];  // level output as seen by the next level
  logic       w_stg_vld [LEVELS];
  logic       w_advance;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam bit REG_HERE = (((k + 1) % REG_EVERY) == 0) || (k == LEVELS - 1);

    if (k == 0) begin : g_src_in
      assign w_lvl_in[k] = w_in;
      assign w_vld_in[k] = bus.in_valid;
    end else begin : g_src_prev
      assign w_lvl_in[k] = w_stg[k-1];
      assign w_vld_in[k] = w_stg_vld[k-1];
    end

    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_level (
      .i_bundle (w_lvl_in[k]),
      .o_bundle (w_lvl_out[k])
    );

    if (REG_HERE) begin : g_reg
      sh_bundle_t r_bundle;
      logic       r_valid;

      // NOTE: payload registers are reset along with the valid bits so the
      // output data and flags read 0 after reset, not leftover state.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_bundle <= '0;
          r_valid  <= 1'b0;
        end else if (w_advance) begin
          // NOTE: non-blocking updates let every stage sample its
          // predecessor's pre-edge value, which is what makes this a pipeline.
          r_bundle <= w_lvl_out[k];
          r_valid  <= w_vld_in[k];
        end
      end

      assign w_stg[k]     = r_bundle;
      assign w_stg_vld[k] = r_valid;
    end else begin : g_comb
      assign w_stg[k]     = w_lvl_out[k];
      assign w_stg_vld[k] = w_vld_in[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Output and global stall
  // ---------------------------------------------------------------------------
  sh_bundle_t w_last;
  logic       w_unused_tail;

  assign w_last    = w_stg[LEVELS-1];
  assign w_advance = !w_stg_vld[LEVELS-1] || bus.out_ready;

  assign bus.in_ready   = w_advance;
  assign bus.out_valid  = w_stg_vld[LEVELS-1];
  assign bus.out_data   = w_last.data[WIDTH-1:0];
  assign bus.out_sticky = w_last.sticky;
  assign bus.out_ovf    = w_last.ovf;

  // Bundle fields that are fully consumed by the time a beat leaves.
  assign w_unused_tail = ^{w_last.amt, w_last.sign, w_last.mode, w_last.data >> WIDTH};

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipe_barrel_shifter
// Directed bench for pipe_barrel_shifter at WIDTH=24, REG_EVERY=1 (L=5).
// Expected results are queued when a beat is accepted and compared when the
// beat is popped at the output.
// -----------------------------------------------------------------------------
module tb_pipe_barrel_shifter;
  import pipe_shift_pkg::*;

  localparam int W   = 24;
  localparam int S   = 5;
  localparam int LAT = 5;

  typedef struct {
    logic [W-1:0] data;
    logic         sticky;
    logic         ovf;
    logic         lat_chk;
    int           acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;

  pipe_barrel_shifter_if #(.WIDTH(W), .SHW(S)) bus ();

  pipe_barrel_shifter #(
    .WIDTH     (W),
    .SHW       (S),
    .REG_EVERY (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks     = 0;
  int           errors     = 0;
  int           cyc        = 0;
  int           pushed     = 0;
  int           popped     = 0;
  int           stall_cnt  = 0;
  exp_t         sb[$];
  exp_t         nxt;
  logic         stall_prev = 1'b0;
  logic [W-1:0] hold_data;
  logic         hold_sticky;
  logic         hold_ovf;
  logic         acc;
  logic [W-1:0] bd [8];
  logic [S-1:0] ba [8];
  sh_mode_e     bm [8];
  int           bi;
  int           bc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] d, input logic s, input logic o,
                              input logic lat);
    exp_t e;
    e.data = d; e.sticky = s; e.ovf = o; e.lat_chk = lat; e.acc_cyc = 0;
    return e;
  endfunction

  // Reference model: wide-word arithmetic, one expression per mode.
  function automatic exp_t model(input logic [W-1:0] d, input logic [S-1:0] a,
                                 input sh_mode_e m);
    exp_t        e;
    logic [63:0] v;
    logic [47:0] r2;
    int          n;
    n = int'(a);
    e = mk('0, 1'b0, 1'b0, 1'b0);
    case (m)
      SH_LSL: begin
        v = {40'b0, d} << n;
        e.data = v[W-1:0];
        e.ovf  = |v[63:W];
      end
      SH_LSR: begin
        v = {8'b0, d, 32'b0} >> n;
        e.data   = v[55:32];
        e.sticky = |v[31:0];
      end
      SH_ASR: begin
        v = 64'($signed({{8{d[W-1]}}, d, 32'b0}) >>> n);
        e.data   = v[55:32];
        e.sticky = (n >= W) ? |d[W-2:0] : |v[31:0];
      end
      default: begin
        r2 = {d, d} >> (n % W);
        e.data = r2[W-1:0];
      end
    endcase
    return e;
  endfunction

  // One clock cycle: sample at the falling edge, account for the handshakes
  // that the next rising edge will complete, then return 1 after that edge.
  task automatic cycle(output logic accepted);
    exp_t e;
    @(negedge clk);
    if (stall_prev) begin
      check("stall_hold_data", bus.out_data, hold_data);
      check("stall_hold_sticky", bus.out_sticky, hold_sticky);
      check("stall_hold_ovf", bus.out_ovf, hold_ovf);
    end
    if (bus.out_valid && !bus.out_ready) begin
      check("stall_in_ready", bus.in_ready, 0);
      stall_cnt++;
    end
    stall_prev  = bus.out_valid && !bus.out_ready;
    hold_data   = bus.out_data;
    hold_sticky = bus.out_sticky;
    hold_ovf    = bus.out_ovf;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat_queue_depth", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("out_data", bus.out_data, e.data);
        check("out_sticky", bus.out_sticky, e.sticky);
        check("out_ovf", bus.out_ovf, e.ovf);
        if (e.lat_chk) check("latency", cyc - e.acc_cyc, LAT);
        popped++;
      end
    end
    accepted = bus.in_valid && bus.in_ready;
    if (accepted) begin
      e = nxt;
      e.acc_cyc = cyc;
      sb.push_back(e);
      pushed++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [S-1:0] a, input sh_mode_e m,
                      input exp_t e);
    logic got;
    int   n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_mode  = m;
    nxt          = e;
    got          = 1'b0;
    n            = 0;
    while (!got && n < 20) begin
      cycle(got);
      n++;
    end
    check("send_accepted", got, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic got;
    for (int k = 0; k < 20 && sb.size() != 0; k++) cycle(got);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = SH_LSL;
    bus.out_ready = 1'b1;
    nxt           = mk('0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_sticky", bus.out_sticky, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);

    // Directed beats, back to back
    send(24'h800001, 5'd4,  SH_LSR, mk(24'h080000, 1'b1, 1'b0, 1'b1));
    send(24'h800000, 5'd30, SH_ASR, mk(24'hFFFFFF, 1'b0, 1'b0, 1'b0));
    send(24'h800010, 5'd3,  SH_ASR, mk(24'hF00002, 1'b0, 1'b0, 1'b0));
    send(24'h000001, 5'd1,  SH_ROR, mk(24'h800000, 1'b0, 1'b0, 1'b0));
    send(24'h000001, 5'd25, SH_ROR, mk(24'h800000, 1'b0, 1'b0, 1'b0));
    send(24'hABCDEF, 5'd0,  SH_ROR, mk(24'hABCDEF, 1'b0, 1'b0, 1'b0));
    send(24'h400001, 5'd2,  SH_LSL, mk(24'h000004, 1'b0, 1'b1, 1'b0));
    send(24'h000003, 5'd31, SH_LSL, mk(24'h000000, 1'b0, 1'b1, 1'b0));
    send(24'h123456, 5'd0,  SH_LSR, mk(24'h123456, 1'b0, 1'b0, 1'b0));
    send(24'h7FFFFF, 5'd24, SH_ASR, mk(24'h000000, 1'b1, 1'b0, 1'b0));
    send(24'hFFFFFF, 5'd23, SH_LSR, mk(24'h000001, 1'b1, 1'b0, 1'b0));
    send(24'h800001, 5'd23, SH_ASR, mk(24'hFFFFFF, 1'b1, 1'b0, 1'b0));
    send(24'hC00000, 5'd26, SH_LSR, mk(24'h000000, 1'b1, 1'b0, 1'b0));
    drain("directed_drained");

    // Backpressure: 8 streamed beats, output stalled for 3 cycles mid-stream
    for (int i = 0; i < 8; i++) begin
      bd[i] = W'($urandom);
      ba[i] = S'($urandom_range(0, 31));
      bm[i] = sh_mode_e'(2'($urandom_range(0, 3)));
    end
    pushed    = 0;
    popped    = 0;
    stall_cnt = 0;
    bi        = 0;
    bc        = 0;
    while (bi < 8 && bc < 40) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = bd[bi];
      bus.in_amt    = ba[bi];
      bus.in_mode   = bm[bi];
      nxt           = model(bd[bi], ba[bi], bm[bi]);
      bus.out_ready = !(bc >= 6 && bc < 9);
      cycle(acc);
      if (acc) bi++;
      bc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_all_accepted", bi, 8);
    drain("bp_drained");
    check("bp_stall_cycles", stall_cnt, 3);
    check("bp_pushed", pushed, 8);
    check("bp_popped", popped, 8);

    // Reset with three beats in flight
    send(24'h000F00, 5'd4, SH_LSR, model(24'h000F00, 5'd4, SH_LSR));
    send(24'h000F00, 5'd4, SH_LSL, model(24'h000F00, 5'd4, SH_LSL));
    send(24'h000F00, 5'd4, SH_ROR, model(24'h000F00, 5'd4, SH_ROR));
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10 && !bus.out_valid; k++) cycle(acc);
    check("rst_mid_pre_valid", bus.out_valid, 1);
    check("rst_mid_in_flight", sb.size(), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_async_valid", bus.out_valid, 0);
    check("rst_mid_out_data", bus.out_data, 0);
    sb.delete();
    stall_prev = 1'b0;
    pushed     = 0;
    popped     = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle(acc);
      check("rst_mid_quiet", bus.out_valid, 0);
    end
    send(24'h800001, 5'd4, SH_LSR, mk(24'h080000, 1'b1, 1'b0, 1'b1));
    drain("rst_mid_drained");
    check("rst_mid_popped", popped, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
